// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
//   Types and constants shared by the banked-RAM arbiter and its
//   round-robin sub-module.
//   - NUM_PORTS  : number of requesting ports
//   - BANK_SEL_W : number of top address bits that select the RAM bank
//   - state_t    : access sequencer state encoding
//   - grant_idx  : one-hot 2-bit grant to port index
package ram_ctrl_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int BANK_SEL_W = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_ADDR = 3'd2,
        READ_DATA = 3'd3,
        TURN      = 3'd4
    } state_t;

    // Grants are one-hot over two ports, so bit 1 alone names the winner.
    function automatic logic grant_idx(input logic [NUM_PORTS-1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-requester round-robin arbiter. The grant is combinational from req;
//   the priority pointer moves only when the caller accepts a grant
//   (advance high), handing priority to the port that did not win.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (port 0 first)
//     req        : request vector
//     advance    : grant accepted this cycle, rotate the pointer
//     grant      : one-hot grant (all zero when nothing requests)
module rr_arbiter2
    import ram_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] grant
);

    // Index of the port that wins when both request.
    logic prio_reg;

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_reg ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_reg <= 1'b0;
        end else if (advance && (grant != '0)) begin
            prio_reg <= ~grant_idx(grant);
        end
    end

endmodule

// File: rtl/ram_large_arbiter.sv
// ram_large_arbiter
//   Two-port arbiter in front of a banked asynchronous RAM with a shared
//   bidirectional data bus. One access is in flight at a time:
//     write : IDLE(gnt) -> WRITE -> IDLE
//     read  : IDLE(gnt) -> READ_ADDR -> READ_DATA -> TURN(rvalid) -> IDLE
//   TURN leaves the bus undriven for one cycle after the RAM has driven it,
//   so a following write never fights the RAM output.
//   Ports:
//     clk, rst_n              : clock, asynchronous active-low reset
//     req, req_we             : per-port request level and op (1 = write)
//     req_addr0/1, req_wdata0/1 : per-port address and write data
//     gnt                     : accept pulse (combinational, IDLE only)
//     rvalid, rdata           : read completion pulse and read data
//     mem_addr, mem_data      : RAM address (top 2 bits = bank), data bus
//     mem_cs, mem_we, mem_oe  : RAM controls
module ram_large_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_PORTS-1:0]  req,
    input  logic [NUM_PORTS-1:0]  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [NUM_PORTS-1:0]  gnt,
    output logic [NUM_PORTS-1:0]  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    state_t                  state_reg;
    logic                    port_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic                    mem_cs_reg;
    logic                    mem_we_reg;
    logic                    mem_oe_reg;
    logic                    drive_reg;
    logic [NUM_PORTS-1:0]    rvalid_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic [NUM_PORTS-1:0]    arb_grant;
    logic                    win;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (gnt != '0),
        .grant   (arb_grant)
    );

    // Grant is only offered from IDLE and is masked while reset is held so
    // nothing is accepted before the first edge with rst_n high.
    assign gnt = (state_reg == IDLE && rst_n) ? arb_grant : '0;
    assign win = grant_idx(arb_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            port_reg     <= 1'b0;
            wdata_reg    <= '0;
            mem_addr_reg <= '0;
            mem_cs_reg   <= 1'b0;
            mem_we_reg   <= 1'b0;
            mem_oe_reg   <= 1'b0;
            drive_reg    <= 1'b0;
            rvalid_reg   <= '0;
            rdata_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt != '0) begin
                        port_reg     <= win;
                        wdata_reg    <= win ? req_wdata1 : req_wdata0;
                        mem_addr_reg <= win ? req_addr1 : req_addr0;
                        mem_cs_reg   <= 1'b1;
                        if (req_we[win]) begin
                            state_reg  <= WRITE;
                            mem_we_reg <= 1'b1;
                            drive_reg  <= 1'b1;
                        end else begin
                            state_reg  <= READ_ADDR;
                            mem_oe_reg <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state_reg    <= IDLE;
                    mem_cs_reg   <= 1'b0;
                    mem_we_reg   <= 1'b0;
                    drive_reg    <= 1'b0;
                    mem_addr_reg <= '0;
                end
                READ_ADDR: begin
                    state_reg <= READ_DATA;
                end
                READ_DATA: begin
                    state_reg    <= TURN;
                    rdata_reg    <= mem_data;
                    rvalid_reg   <= port_reg ? 2'b10 : 2'b01;
                    mem_cs_reg   <= 1'b0;
                    mem_oe_reg   <= 1'b0;
                    mem_addr_reg <= '0;
                end
                TURN: begin
                    state_reg  <= IDLE;
                    rvalid_reg <= '0;
                end
                default: begin
                    state_reg  <= IDLE;
                    mem_cs_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                    mem_oe_reg <= 1'b0;
                    drive_reg  <= 1'b0;
                    rvalid_reg <= '0;
                end
            endcase
        end
    end

    // drive_reg is only set together with mem_we, never with mem_oe.
    assign mem_data = drive_reg ? wdata_reg : {DATA_WIDTH{1'bz}};
    assign mem_addr = mem_addr_reg;
    assign mem_cs   = mem_cs_reg;
    assign mem_we   = mem_we_reg;
    assign mem_oe   = mem_oe_reg;
    assign rvalid   = rvalid_reg;
    assign rdata    = rdata_reg;

endmodule
